// File: rtl/bnn_seq_core.sv
// Time-multiplexed XNOR-popcount BNN core: one shared neuron unit walks N + N + OUT_N neurons,
// one per clock. A valid/ready stream loads weights and thresholds while the core is idle.
module bnn_seq_core #(
  parameter int N      = 8,
  parameter int OUT_N  = 4,
  parameter int LOAD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N-1:0]      in_vec,
  output logic              busy,
  output logic              out_valid,
  output logic [OUT_N-1:0]  out_vec,
  input  logic              load_valid,
  input  logic [LOAD_W-1:0] load_data,
  output logic              load_ready,
  output logic              cfg_loaded
);
  localparam int TW  = $clog2(N + 1);
  localparam int NN  = 2 * N + OUT_N;
  localparam int BPN = N / LOAD_W;
  localparam int KW  = $clog2(NN);
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int BW  = $clog2(BPN + 1);

  typedef enum logic [2:0] {IDLE, L1, L2, L3, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      w [NN];
  logic [TW-1:0]     t [NN];
  logic [N-1:0]      x0, h1, h2;
  logic [OUT_N-1:0]  acc, acc_nxt;
  logic [KW-1:0]     nptr;
  logic [BW-1:0]     bptr;
  logic [KW-1:0]     k;
  logic [N-1:0]      x_sel, match;
  logic [TW-1:0]     ones;
  logic              last, fire, load_fire;

  assign busy       = (state != IDLE);
  assign load_ready = (state == IDLE) && !start;
  assign load_fire  = load_valid && load_ready;

  // Neuron selection: layer base plus position within the layer.
  always_comb begin
    k     = '0;
    x_sel = x0;
    last  = 1'b0;
    case (state)
      L1: begin
        k    = KW'(cnt);
        last = (cnt == CW'(N - 1));
      end
      L2: begin
        k     = KW'(N) + KW'(cnt);
        x_sel = h1;
        last  = (cnt == CW'(N - 1));
      end
      L3: begin
        k     = KW'(2 * N) + KW'(cnt);
        x_sel = h2;
        last  = (cnt == CW'(OUT_N - 1));
      end
      default: ;
    endcase
  end

  always_comb begin
    match = ~(x_sel ^ w[k]);
    ones  = '0;
    for (int i = 0; i < N; i++) ones = ones + TW'(match[i]);
    fire = (ones >= t[k]);
  end

  // The final output bit is computed on the same edge that publishes out_vec.
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < OUT_N; i++)
      if (cnt == CW'(i)) acc_nxt[i] = fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = L1;
      L1:      if (last)  state_nxt = L2;
      L2:      if (last)  state_nxt = L3;
      L3:      if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      x0         <= '0;
      h1         <= '0;
      h2         <= '0;
      acc        <= '0;
      out_vec    <= '0;
      out_valid  <= 1'b0;
      nptr       <= '0;
      bptr       <= '0;
      cfg_loaded <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        w[i] <= '0;
        t[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x0  <= in_vec;
          cnt <= '0;
        end
        L1: begin
          for (int i = 0; i < N; i++) if (cnt == CW'(i)) h1[i] <= fire;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        L2: begin
          for (int i = 0; i < N; i++) if (cnt == CW'(i)) h2[i] <= fire;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        L3: begin
          acc <= acc_nxt;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            out_vec   <= acc_nxt;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase

      // Weight chunks land first, then the threshold beat advances the neuron pointer.
      if (load_fire) begin
        if (bptr == BW'(BPN)) begin
          t[nptr] <= load_data[TW-1:0];
          bptr    <= '0;
          if (nptr == KW'(NN - 1)) begin
            nptr       <= '0;
            cfg_loaded <= 1'b1;
          end else begin
            nptr <= nptr + KW'(1);
          end
        end else begin
          for (int j = 0; j < BPN; j++)
            if (bptr == BW'(j)) w[nptr][j*LOAD_W +: LOAD_W] <= load_data;
          bptr <= bptr + BW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_bnn_seq_core.sv
// Scenario bench for bnn_seq_core with default parameters; a behavioural network model feeds a result queue.
module tb_bnn_seq_core;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_vec = '0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic       busy, out_valid, load_ready, cfg_loaded;
  logic [3:0] out_vec;

  int errors = 0;
  int checks = 0;
  logic [3:0] sb[$];

  logic [7:0] mw[20];
  logic [3:0] mt[20];
  int mn, mb;
  logic [7:0] img_w[20];
  logic [3:0] img_t[20];

  bnn_seq_core dut (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec),
    .busy(busy), .out_valid(out_valid), .out_vec(out_vec),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .cfg_loaded(cfg_loaded)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_eval(input logic [7:0] v);
    logic [7:0] x, h;
    x = v;
    for (int l = 0; l < 3; l++) begin
      h = '0;
      for (int c = 0; c < ((l < 2) ? 8 : 4); c++)
        h[c] = ($countones(~(x ^ mw[l*8+c])) >= int'(mt[l*8+c]));
      x = h;
    end
    return x[3:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 20; i++) begin
      mw[i] = '0;
      mt[i] = '0;
    end
    mn = 0;
    mb = 0;
  endtask

  task automatic model_beat(input logic [3:0] d);
    if (mb < 2) begin
      mw[mn][mb*4 +: 4] = d;
      mb++;
    end else begin
      mt[mn] = d;
      mb = 0;
      mn = (mn == 19) ? 0 : mn + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    sb.delete();
  endtask

  task automatic send_beat(input logic [3:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_idle: got %b expected 1", load_ready);
    end
    @(posedge clk);
    model_beat(d);
    #1 load_valid = 1'b0;
  endtask

  task automatic send_beats_from(input int b0, input int n);
    logic [3:0] d;
    for (int b = b0; b < b0 + n; b++) begin
      case (b % 3)
        0:       d = img_w[b/3][3:0];
        1:       d = img_w[b/3][7:4];
        default: d = img_t[b/3];
      endcase
      send_beat(d);
    end
  endtask

  task automatic run_inference(input logic [7:0] v);
    int cyc;
    logic [3:0] exp_v;
    @(negedge clk);
    start  = 1'b1;
    in_vec = v;
    sb.push_back(model_eval(v));
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (cyc != 20) begin
      errors++;
      $display("FAIL latency in=%h: got %0d cycles expected 20", v, cyc);
    end
    exp_v = sb.pop_front();
    checks++;
    if (out_vec !== exp_v) begin
      errors++;
      $display("FAIL out_vec in=%h: got %h expected %h", v, out_vec, exp_v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_vec !== exp_v) begin
      errors++;
      $display("FAIL after_done: got valid=%b busy=%b out=%h expected 0 0 %h",
               out_valid, busy, out_vec, exp_v);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({busy, out_valid, out_vec, cfg_loaded, load_ready} !== 8'b0_0_0000_0_1) begin
      errors++;
      $display("FAIL reset_values: got busy=%b valid=%b out=%h cfg=%b rdy=%b expected 0 0 0 0 1",
               busy, out_valid, out_vec, cfg_loaded, load_ready);
    end
    run_inference(8'h00);
    for (int i = 0; i < 20; i++) begin
      img_w[i] = 8'($urandom);
      img_t[i] = 4'd0;
    end
    send_beats_from(0, 60);
    checks++;
    if (cfg_loaded !== 1'b1) begin
      errors++;
      $display("FAIL cfg_before_abort: got %b expected 1", cfg_loaded);
    end
    @(negedge clk);
    start  = 1'b1;
    in_vec = 8'h5A;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_vec !== 4'h0 || cfg_loaded !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_l2: got busy=%b out=%h cfg=%b valid=%b expected 0 0 0 0",
               busy, out_vec, cfg_loaded, out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    sb.delete();
    run_inference(8'h00);
  endtask

  task automatic test_full_load(input logic [3:0] thr, input logic [3:0] exp_out);
    for (int i = 0; i < 20; i++) begin
      img_w[i] = 8'hF0;
      img_t[i] = thr;
    end
    send_beats_from(0, 59);
    checks++;
    if (cfg_loaded !== 1'b1 && thr == 4'd5) begin
      errors++;
      $display("FAIL cfg_sticky: got %b expected 1", cfg_loaded);
    end else if (cfg_loaded !== 1'b0 && thr == 4'd4) begin
      errors++;
      $display("FAIL cfg_early: got %b expected 0", cfg_loaded);
    end
    send_beats_from(59, 1);
    checks++;
    if (cfg_loaded !== 1'b1) begin
      errors++;
      $display("FAIL cfg_after_last: got %b expected 1", cfg_loaded);
    end
    checks++;
    if (model_eval(8'hF0) !== exp_out) begin
      errors++;
      $display("FAIL model_sanity thr=%0d: got %h expected %h", thr, model_eval(8'hF0), exp_out);
    end
    run_inference(8'hF0);
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < 20; i++) begin
      img_w[i] = 8'($urandom);
      img_t[i] = (i >= 16) ? 4'd9 : 4'($urandom_range(8, 0));
    end
    send_beats_from(0, 60);
    for (int r = 0; r < 3; r++) run_inference(8'($urandom));
    for (int i = 0; i < 20; i++) img_t[i] = 4'd0;
    send_beats_from(0, 60);
    for (int r = 0; r < 3; r++) run_inference(8'($urandom));
    for (int i = 0; i < 20; i++) img_t[i] = 4'($urandom_range(6, 2));
    send_beats_from(0, 60);
    for (int r = 0; r < 4; r++) run_inference(8'($urandom));
  endtask

  task automatic test_handshake();
    int pulses;
    logic bad_rdy;
    logic [7:0] v;
    logic [3:0] exp_v;
    pulses  = 0;
    bad_rdy = 1'b0;
    v = 8'($urandom);
    @(negedge clk);
    start      = 1'b1;
    in_vec     = v;
    load_valid = 1'b1;
    load_data  = 4'hA;
    sb.push_back(model_eval(v));
    #1;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_beats_load: got load_ready=%b expected 0", load_ready);
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1 && load_ready !== 1'b0) bad_rdy = 1'b1;
      if (cyc == 17) start = 1'b1;
      if (cyc == 18) start = 1'b0;
      if (out_valid === 1'b1) begin
        pulses++;
        load_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++;
        if (out_vec !== exp_v || cyc != 20) begin
          errors++;
          $display("FAIL handshake_result: got %h at cycle %0d expected %h at 20", out_vec, cyc, exp_v);
        end
      end
    end
    load_valid = 1'b0;
    checks++;
    if (bad_rdy) begin
      errors++;
      $display("FAIL ready_while_busy: got load_ready=1 expected 0");
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL start_in_l3: got %0d out_valid pulses expected 1", pulses);
    end
    for (int i = 0; i < 20; i++) begin
      img_w[i] = 8'($urandom);
      img_t[i] = 4'($urandom_range(6, 2));
    end
    send_beats_from(0, 60);
    for (int r = 0; r < 3; r++) run_inference(8'($urandom));
  endtask

  task automatic test_partial();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      img_w[i] = 8'($urandom);
      img_t[i] = 4'($urandom_range(6, 2));
    end
    send_beats_from(0, 10);
    checks++;
    if (cfg_loaded !== 1'b0) begin
      errors++;
      $display("FAIL partial_cfg_10: got %b expected 0", cfg_loaded);
    end
    run_inference(8'($urandom));
    send_beats_from(10, 49);
    checks++;
    if (cfg_loaded !== 1'b0) begin
      errors++;
      $display("FAIL partial_cfg_59: got %b expected 0", cfg_loaded);
    end
    send_beats_from(59, 1);
    checks++;
    if (cfg_loaded !== 1'b1) begin
      errors++;
      $display("FAIL partial_cfg_60: got %b expected 1", cfg_loaded);
    end
    run_inference(8'($urandom));
    img_w[0] = ~img_w[0];
    img_t[0] = 4'd8;
    send_beats_from(0, 3);
    for (int r = 0; r < 3; r++) run_inference(8'($urandom));
  endtask

  initial begin
    model_clear();
    test_reset();
    test_full_load(4'd4, 4'hF);
    test_full_load(4'd5, 4'h0);
    test_boundaries();
    test_handshake();
    test_partial();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
